// File: rtl/pong_pkg.sv
// Shared types and constants for the pong score keeper and its BCD helper.
package pong_pkg;

    localparam int LCD_HEIGHT_DEF = 320;
    localparam int BALL_SIZE_DEF  = 8;
    localparam int MAX_SCORE_DEF  = 10;
    localparam int HOLD_TICKS_DEF = 60;

    localparam int SCORE_W = 4;
    localparam int HOLD_W  = 8;
    localparam int BALL_W  = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        HOLD  = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    // Match bookkeeping that moves together on a goal or a new game.
    typedef struct packed {
        logic [SCORE_W-1:0] score_1;
        logic [SCORE_W-1:0] score_2;
        logic [1:0]         winner;
        logic               serve_dir;
        logic               goal;
        logic [HOLD_W-1:0]  hold_cnt;
    } match_t;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic [SCORE_W-1:0] lim);
        return (s >= lim) ? lim : s + 1'b1;
    endfunction

    function automatic logic [7:0] bin_to_bcd(input logic [SCORE_W-1:0] b);
        logic       tens;
        logic [3:0] ones;
        tens = (b >= 4'd10);
        ones = tens ? b - 4'd10 : b;
        return {3'b000, tens, ones};
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Bus between the score keeper and the rest of the game; SCORE_BCD_EN adds BCD scores.
interface score_keeper_if;
    import pong_pkg::*;

    logic               game_tick;
    logic [BALL_W-1:0]  ball_y;
    logic               start;
    logic               serve_ack;
    logic               serve_req;
    logic               serve_dir;
    logic               freeze;
    logic               goal_pulse;
    logic [SCORE_W-1:0] score_1;
    logic [SCORE_W-1:0] score_2;
    logic               game_over;
    logic [1:0]         winner;
`ifdef SCORE_BCD_EN
    logic [7:0]         score_1_bcd;
    logic [7:0]         score_2_bcd;
`endif

    modport master (
        output game_tick, ball_y, start, serve_ack,
        input  serve_req, serve_dir, freeze, goal_pulse, score_1, score_2, game_over, winner
`ifdef SCORE_BCD_EN
        , input score_1_bcd, score_2_bcd
`endif
    );

    modport slave (
        input  game_tick, ball_y, start, serve_ack,
        output serve_req, serve_dir, freeze, goal_pulse, score_1, score_2, game_over, winner
`ifdef SCORE_BCD_EN
        , output score_1_bcd, score_2_bcd
`endif
    );

endinterface

// File: rtl/score_to_bcd.sv
// Registered 4-bit binary to two-digit BCD converter.
module score_to_bcd
    import pong_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [SCORE_W-1:0] bin,
    output logic [7:0]         bcd
);

    always_ff @(posedge clock) begin
        if (reset) bcd <= '0;
        else       bcd <= bin_to_bcd(bin);
    end

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: serve handshake, goal detection, post-goal hold and game-over.
// Optional SCORE_BCD_EN adds registered BCD copies of both scores.
module score_keeper
    import pong_pkg::*;
#(
    parameter int LCD_HEIGHT = LCD_HEIGHT_DEF,
    parameter int BALL_SIZE  = BALL_SIZE_DEF,
    parameter int MAX_SCORE  = MAX_SCORE_DEF,
    parameter int HOLD_TICKS = HOLD_TICKS_DEF
) (
    input  logic clock,
    input  logic reset,
    score_keeper_if.slave bus
);

    localparam logic [BALL_W-1:0]  GOAL2_Y   = BALL_W'(LCD_HEIGHT - BALL_SIZE);
    localparam logic [SCORE_W-1:0] MAX_S     = SCORE_W'(MAX_SCORE);
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(HOLD_TICKS);

    state_t state_q, state_n;
    match_t m_q, m_n;
    logic   serve_req_q, freeze_q, game_over_q;
    logic   goal_1, goal_2;

    // Player 1 wins the tie if both zones ever overlap.
    assign goal_1 = (bus.ball_y == '0);
    assign goal_2 = (bus.ball_y >= GOAL2_Y);

    always_comb begin
        state_n = state_q;
        m_n     = m_q;
        m_n.goal = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    m_n.score_1   = '0;
                    m_n.score_2   = '0;
                    m_n.winner    = WIN_NONE;
                    m_n.serve_dir = 1'b0;
                    state_n       = SERVE;
                end
            end
            SERVE: begin
                if (bus.serve_ack) state_n = PLAY;
            end
            PLAY: begin
                if (bus.game_tick && (goal_1 || goal_2)) begin
                    m_n.goal = 1'b1;
                    if (goal_1) begin
                        m_n.score_1   = sat_inc(m_q.score_1, MAX_S);
                        m_n.serve_dir = 1'b1;
                    end else begin
                        m_n.score_2   = sat_inc(m_q.score_2, MAX_S);
                        m_n.serve_dir = 1'b0;
                    end
                    if (goal_1 ? (m_n.score_1 == MAX_S) : (m_n.score_2 == MAX_S)) begin
                        m_n.winner = goal_1 ? WIN_P1 : WIN_P2;
                        state_n    = OVER;
                    end else begin
                        m_n.hold_cnt = HOLD_INIT;
                        state_n      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.game_tick) begin
                    if (m_q.hold_cnt <= HOLD_W'(1)) begin
                        m_n.hold_cnt = '0;
                        state_n      = SERVE;
                    end else begin
                        m_n.hold_cnt = m_q.hold_cnt - 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Flag outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            m_q         <= '0;
            serve_req_q <= 1'b0;
            freeze_q    <= 1'b1;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            m_q         <= m_n;
            serve_req_q <= (state_n == SERVE);
            freeze_q    <= (state_n != PLAY);
            game_over_q <= (state_n == OVER);
        end
    end

    assign bus.serve_req  = serve_req_q;
    assign bus.serve_dir  = m_q.serve_dir;
    assign bus.freeze     = freeze_q;
    assign bus.goal_pulse = m_q.goal;
    assign bus.score_1    = m_q.score_1;
    assign bus.score_2    = m_q.score_2;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = m_q.winner;

`ifdef SCORE_BCD_EN
    // Fed from next-state scores so the BCD copies change with the binary ones.
    score_to_bcd u_bcd_1 (
        .clock (clock),
        .reset (reset),
        .bin   (m_n.score_1),
        .bcd   (bus.score_1_bcd)
    );
    score_to_bcd u_bcd_2 (
        .clock (clock),
        .reset (reset),
        .bin   (m_n.score_2),
        .bcd   (bus.score_2_bcd)
    );
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Randomized scoreboard bench for score_keeper against a match-level model.
module tb_score_keeper;

    localparam int LCD_HEIGHT = 320;
    localparam int BALL_SIZE  = 8;
    localparam int MAX_SCORE  = 10;
    localparam int HOLD_TICKS = 60;
    localparam int GOAL2_Y    = LCD_HEIGHT - BALL_SIZE;

    typedef struct {
        int s1;
        int s2;
        int dir;
        int over;
        int win;
    } exp_t;

    logic clock;
    logic reset;
    score_keeper_if bus ();

    score_keeper #(
        .LCD_HEIGHT (LCD_HEIGHT),
        .BALL_SIZE  (BALL_SIZE),
        .MAX_SCORE  (MAX_SCORE),
        .HOLD_TICKS (HOLD_TICKS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Match-level reference state.
    int m_s1, m_s2, m_dir, m_win, m_over;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int bcd_of(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: every goal_pulse must match a queued expectation.
    always @(negedge clock) begin
        exp_t e;
        if (bus.goal_pulse) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL goal_pulse_unexpected: got 1, required 0");
            end else begin
                e = exp_q.pop_front();
                check("goal_score_1", int'(bus.score_1), e.s1);
                check("goal_score_2", int'(bus.score_2), e.s2);
                check("goal_serve_dir", int'(bus.serve_dir), e.dir);
                check("goal_game_over", int'(bus.game_over), e.over);
                check("goal_winner", int'(bus.winner), e.win);
                check("goal_freeze", int'(bus.freeze), 1);
`ifdef SCORE_BCD_EN
                check("goal_bcd_1", int'(bus.score_1_bcd), bcd_of(e.s1));
                check("goal_bcd_2", int'(bus.score_2_bcd), bcd_of(e.s2));
`endif
            end
        end
    end

    task automatic idle_inputs();
        bus.game_tick = 1'b0;
        bus.start     = 1'b0;
        bus.serve_ack = 1'b0;
        bus.ball_y    = 9'd160;
    endtask

    task automatic model_new_game();
        m_s1 = 0; m_s2 = 0; m_dir = 0; m_win = 0; m_over = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_serve_req"}, int'(bus.serve_req), 0);
        check({tag, "_freeze"}, int'(bus.freeze), 1);
        check({tag, "_goal_pulse"}, int'(bus.goal_pulse), 0);
        check({tag, "_score_1"}, int'(bus.score_1), 0);
        check({tag, "_score_2"}, int'(bus.score_2), 0);
        check({tag, "_winner"}, int'(bus.winner), 0);
        check({tag, "_game_over"}, int'(bus.game_over), 0);
        check({tag, "_serve_dir"}, int'(bus.serve_dir), 0);
`ifdef SCORE_BCD_EN
        check({tag, "_bcd_1"}, int'(bus.score_1_bcd), 0);
        check({tag, "_bcd_2"}, int'(bus.score_2_bcd), 0);
`endif
    endtask

    task automatic pulse_reset(input string tag);
        idle_inputs();
        reset = 1'b1;
        cyc();
        check_reset(tag);
        reset = 1'b0;
        model_new_game();
        // After reset the block must sit in IDLE and ignore a stray ack.
        bus.serve_ack = 1'b1;
        cyc();
        bus.serve_ack = 1'b0;
        check({tag, "_idle_serve_req"}, int'(bus.serve_req), 0);
        check({tag, "_idle_freeze"}, int'(bus.freeze), 1);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        model_new_game();
        check("start_serve_req", int'(bus.serve_req), 1);
        check("start_serve_dir", int'(bus.serve_dir), 0);
        check("start_score_1", int'(bus.score_1), 0);
        check("start_score_2", int'(bus.score_2), 0);
        check("start_winner", int'(bus.winner), 0);
        check("start_game_over", int'(bus.game_over), 0);
        check("start_freeze", int'(bus.freeze), 1);
    endtask

    task automatic serve_handshake();
        int wait_n;
        check("serve_req_high", int'(bus.serve_req), 1);
        check("serve_dir", int'(bus.serve_dir), m_dir);
        wait_n = $urandom_range(0, 3);
        for (int i = 0; i < wait_n; i++) begin
            bus.start = 1'($urandom_range(0, 1));
            cyc();
        end
        bus.start     = 1'b0;
        bus.serve_ack = 1'b1;
        cyc();
        bus.serve_ack = 1'b0;
        check("play_freeze", int'(bus.freeze), 0);
        check("play_serve_req", int'(bus.serve_req), 0);
    endtask

    task automatic play_noise();
        int n;
        n = $urandom_range(1, 8);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: begin bus.ball_y = 9'd0; bus.game_tick = 1'b0; end
                1: begin bus.ball_y = 9'($urandom_range(1, GOAL2_Y - 1)); bus.start = 1'b1; end
                default: begin
                    bus.ball_y    = 9'($urandom_range(1, GOAL2_Y - 1));
                    bus.game_tick = 1'($urandom_range(0, 1));
                end
            endcase
            cyc();
            bus.game_tick = 1'b0;
            bus.start     = 1'b0;
        end
        bus.ball_y    = 9'(GOAL2_Y - 1);
        bus.game_tick = 1'b1;
        cyc();
        bus.game_tick = 1'b0;
        check("noise_score_1", int'(bus.score_1), m_s1);
        check("noise_score_2", int'(bus.score_2), m_s2);
        check("noise_freeze", int'(bus.freeze), 0);
    endtask

    function automatic logic [8:0] goal_y(input int p);
        if (p == 1) return 9'd0;
        if ((m_s2 % 2) == 0) return 9'(GOAL2_Y);
        return 9'(GOAL2_Y + $urandom_range(0, 511 - GOAL2_Y));
    endfunction

    task automatic score_goal(input int p);
        exp_t e;
        bus.ball_y    = goal_y(p);
        bus.game_tick = 1'b1;
        if (p == 1) begin m_s1++; m_dir = 1; end
        else        begin m_s2++; m_dir = 0; end
        if (m_s1 == MAX_SCORE || m_s2 == MAX_SCORE) begin
            m_over = 1;
            m_win  = p;
        end
        e.s1 = m_s1; e.s2 = m_s2; e.dir = m_dir; e.over = m_over; e.win = m_win;
        exp_q.push_back(e);
        cyc();
        bus.game_tick = 1'b0;
        check("goal_serve_req", int'(bus.serve_req), 0);
    endtask

    task automatic hold_phase(input int p);
        int gap;
        for (int i = 1; i <= HOLD_TICKS; i++) begin
            bus.ball_y    = (i <= 5) ? goal_y(p) : 9'($urandom_range(1, GOAL2_Y - 1));
            bus.game_tick = 1'b1;
            cyc();
            bus.game_tick = 1'b0;
            if (i == 5) begin
                check("hold_no_recount_1", int'(bus.score_1), m_s1);
                check("hold_no_recount_2", int'(bus.score_2), m_s2);
            end
            if (i == HOLD_TICKS - 1) check("hold_not_done", int'(bus.serve_req), 0);
            if (i == HOLD_TICKS)     check("hold_done", int'(bus.serve_req), 1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) cyc();
        end
    endtask

    // capped: this player may not take the final point, fixing the winner.
    task automatic play_game(input int capped);
        int p;
        while (m_over == 0) begin
            serve_handshake();
            play_noise();
            p = $urandom_range(1, 2);
            if (p == capped && ((p == 1) ? m_s1 : m_s2) == MAX_SCORE - 1) p = 3 - p;
            score_goal(p);
            if (m_over == 0) hold_phase(p);
        end
    endtask

    task automatic after_over();
        cyc();
        check("over_game_over", int'(bus.game_over), 1);
        check("over_winner", int'(bus.winner), m_win);
        check("over_freeze", int'(bus.freeze), 1);
        for (int i = 0; i < 3; i++) begin
            bus.ball_y    = 9'd0;
            bus.game_tick = 1'b1;
            bus.serve_ack = 1'b1;
            cyc();
        end
        idle_inputs();
        check("over_serve_req", int'(bus.serve_req), 0);
        check("over_score_1", int'(bus.score_1), m_s1);
        check("over_score_2", int'(bus.score_2), m_s2);
    endtask

    initial begin
        idle_inputs();
        model_new_game();
        reset = 1'b1;
        cyc();
        cyc();
        check_reset("por");
        reset = 1'b0;

        bus.serve_ack = 1'b1;
        bus.game_tick = 1'b1;
        bus.ball_y    = 9'd0;
        cyc();
        idle_inputs();
        check("idle_serve_req", int'(bus.serve_req), 0);
        check("idle_freeze", int'(bus.freeze), 1);

        do_start();
        play_game(2);
        after_over();

        do_start();
        play_game(1);
        after_over();

        do_start();
        serve_handshake();
        score_goal(1);
        for (int i = 0; i < 10; i++) begin
            bus.game_tick = 1'b1;
            cyc();
            bus.game_tick = 1'b0;
        end
        pulse_reset("mid_hold");

        do_start();
        cyc();
        cyc();
        pulse_reset("mid_serve");

        cyc();
        cyc();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter LCD_HEIGHT, default 320: screen rows, y = 0 at the player-2 (top) edge.
REQ-002 Parameter BALL_SIZE, default 8: ball height in pixels.
REQ-003 Parameter MAX_SCORE, default 10: winning score, legal range 1..15.
REQ-004 Parameter HOLD_TICKS, default 60: game ticks of pause after a goal, legal range 1..255.
REQ-005 clock  in  1  system clock (50 MHz); the only clock in the block.
REQ-006 reset  in  1  reset; synchronous, active-high.
REQ-007 game_tick  in  1  one-cycle enable at the game rate (30 Hz).
REQ-008 ball_y  in  9  ball top-row position from the ball stage.
REQ-009 start  in  1  one-cycle new-game request.
REQ-010 serve_ack  in  1  ball stage has re-centred the ball and accepted serve_dir.
REQ-011 serve_req  out  1  level-sensitive serve request to the ball stage.
REQ-012 serve_dir  out  1  0 = serve downward toward player 1, 1 = serve upward toward player 2.
REQ-013 freeze  out  1  ball and paddles hold position while high.
REQ-014 goal_pulse  out  1  one-cycle strobe on every scored goal.
REQ-015 score_1, score_2  out  4 each  binary scores.
REQ-016 game_over  out  1  high while in OVER.
REQ-017 winner  out  2  00 none, 01 player 1, 10 player 2.

Function
REQ-018 The FSM SHALL have five states: IDLE, SERVE, PLAY, HOLD, OVER; all outputs are registered.
REQ-019 IDLE or OVER plus start SHALL clear both scores and winner, set serve_dir=0, and enter SERVE on the next cycle; start is ignored in every other state.
REQ-020 serve_req SHALL be high exactly while in SERVE; the first cycle in SERVE with serve_ack=1 SHALL enter PLAY on the next cycle; serve_ack in any other state is ignored.
REQ-021 freeze SHALL be high in every state except PLAY.
REQ-022 Goals SHALL be sampled only in PLAY on a cycle with game_tick=1.
REQ-023 If ball_y == 0, player 1 scores: score_1 increments and serve_dir is set to 1.
REQ-024 If ball_y >= LCD_HEIGHT-BALL_SIZE (unsigned 9-bit compare), player 2 scores: score_2 increments and serve_dir is set to 0.
REQ-025 On a goal, the score, serve_dir and goal_pulse SHALL all update one cycle after the sampling cycle.
REQ-026 A goal whose new score equals MAX_SCORE SHALL enter OVER directly, set winner and game_over, and skip HOLD; any other goal SHALL enter HOLD.
REQ-027 HOLD SHALL load its counter with HOLD_TICKS, decrement on each game_tick, and enter SERVE on the tick that reaches 0.
REQ-028 Scores SHALL never exceed MAX_SCORE and never wrap.
REQ-029 Once HOLD or OVER is entered, no further goal SHALL be counted until PLAY is re-entered, even if ball_y stays in a goal zone.

Reset
REQ-030 When reset is high, the block SHALL on that clock edge enter IDLE and set score_1=0, score_2=0, winner=00, serve_dir=0, serve_req=0, goal_pulse=0, game_over=0, freeze=1, and hold counter=0.
REQ-031 Reset SHALL take priority over all other inputs and abort any state, including a pending serve handshake.

Configuration
REQ-032 Macro SCORE_BCD_EN:
- Defined: the block SHALL add outputs score_1_bcd and score_2_bcd (8 bits each: tens nibble, ones nibble), updated in the same cycle as the binary scores and reset to 0.
- Undefined: these ports and their logic SHALL be absent, and the rest of the behaviour is unchanged.

Structure
REQ-033 Package pong_pkg SHALL hold the state enum, the SCORE_W=4 constant, the winner encodings and the parameter defaults.
REQ-034 Sub-module score_to_bcd (4-bit binary to 8-bit BCD, registered) SHALL be instantiated twice, only under SCORE_BCD_EN.

Verification
REQ-035 reset, then start -> serve_req=1 and serve_dir=0; serve_ack one cycle -> PLAY, freeze=0.
REQ-036 In PLAY, ball_y=0 with game_tick -> score_1=1, goal_pulse one cycle, serve_dir=1, freeze=1; after exactly 60 ticks -> serve_req=1.
REQ-037 In PLAY, ball_y=312 with game_tick -> score_2 increments; ball_y=311 -> no change.
REQ-038 score_2=9, then a player-2 goal -> score_2=10, game_over=1, winner=10, no HOLD; later start -> scores 0, SERVE.
REQ-039 ball_y held at 0 for 5 ticks -> exactly one goal counted; ball_y=0 without game_tick -> no goal.
REQ-040 reset asserted mid-HOLD and mid-SERVE -> IDLE with all outputs at reset values; with SCORE_BCD_EN, score 10 -> bcd=8'h10.
